// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: FSM state encoding,
// the clocks-per-bit calculation and the frame data width.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  function automatic int calc_cpb(input int clock_freq, input int bit_rate);
    return clock_freq / bit_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read port and explicit occupancy count.
// DEPTH must be a power of 2 so the pointers wrap for free.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign pop   = rd_en & ~empty;
  // A write into a full FIFO only lands if a pop frees the head slot this edge.
  assign push  = wr_en & (~full | pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Storage is not reset, so the port reads zero while nothing is queued.
  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN defined) feeding a
// show-ahead receive FIFO, with sticky framing/overrun (and parity) flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 25000000,
  parameter int BIT_RATE   = 9600,
  parameter int FIFO_DEPTH = 16,
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 empty,
  output logic                 full,
  output logic [CNT_W-1:0]     count,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  input  logic                 clr_err
);

  localparam int CPB   = calc_cpb(CLOCK_FREQ, BIT_RATE);
  localparam int CYC_W = $clog2(CPB);
  localparam int BIT_W = $clog2(DATA_BITS);

  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_d;
  logic [1:0]           warm;
  logic                 start_edge;

  rx_state_t            state;
  rx_state_t            state_nxt;
  logic [CYC_W-1:0]     cyc_cnt;
  logic [CYC_W-1:0]     cyc_nxt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W-1:0]     bit_nxt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_nxt;
  logic                 cyc_half;
  logic                 cyc_last;

  logic                 push_req;
  logic                 frame_set;
  logic                 overrun_set;

`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
  logic                 par_bad_nxt;
  logic                 parity_set;
`endif

  // Input synchroniser and edge-detect flop; all idle high out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
      warm    <= '0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
      if (warm != 2'd3) warm <= warm + 2'd1;
    end
  end

  // Edges are only trusted once rx_d holds a real pin sample, so a line that
  // is still low when reset releases does not look like a start bit.
  assign start_edge = (warm == 2'd3) & rx_d & ~rx_s;

  assign cyc_half = (cyc_cnt == CYC_W'(CPB / 2 - 1));
  assign cyc_last = (cyc_cnt == CYC_W'(CPB - 1));

  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc_cnt + 1'b1;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_reg;
    push_req  = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nxt = par_bad;
    parity_set  = 1'b0;
`endif
    case (state)
      IDLE: begin
        cyc_nxt = '0;
        if (start_edge) state_nxt = START;
      end
      START: begin
        if (cyc_half) begin
          cyc_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
          par_bad_nxt = 1'b0;
`endif
        end
      end
      DATA: begin
        if (cyc_last) begin
          cyc_nxt   = '0;
          shift_nxt = {rx_s, shift_reg[DATA_BITS-1:1]};
          bit_nxt   = bit_cnt + 1'b1;
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cyc_last) begin
          cyc_nxt     = '0;
          par_bad_nxt = ^{shift_reg, rx_s};
          parity_set  = ^{shift_reg, rx_s};
          state_nxt   = STOP;
        end
      end
`endif
      STOP: begin
        if (cyc_last) begin
          cyc_nxt   = '0;
          state_nxt = IDLE;
          if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            push_req = ~par_bad;
`else
            push_req = 1'b1;
`endif
          end else begin
            frame_set = 1'b1;
          end
        end
      end
      default: begin
        cyc_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cyc_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      cyc_cnt <= cyc_nxt;
      bit_cnt <= bit_nxt;
    end
  end

  always_ff @(posedge clk) begin
    shift_reg <= shift_nxt;
  end

  // Sticky flags: a new error in the same cycle as clr_err takes priority.
  assign overrun_set = push_req & full & ~rd_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= (frame_err & ~clr_err) | frame_set;
      overrun   <= (overrun & ~clr_err) | overrun_set;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad    <= par_bad_nxt;
      parity_err <= (parity_err & ~clr_err) | parity_set;
    end
  end
`endif

  sync_fifo #(
    .DATA_W (DATA_BITS),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_req),
    .wr_data (shift_reg),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver with a built-in receive FIFO.
- Sits between the board `rx` pin and the Risco-5 SoC peripheral bus: the pin is deserialised, bytes are buffered, and the SoC pops them through a show-ahead read port.
- Reports framing and overrun errors through sticky status flags.

Parameters:
- CLOCK_FREQ, 25000000: system clock frequency in Hz.
- BIT_RATE, 9600: baud rate. CPB = CLOCK_FREQ/BIT_RATE (integer division); CPB must be >= 4.
- FIFO_DEPTH, 16: number of byte entries; must be a power of 2 and >= 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rx  input  1  asynchronous serial line, idle high
- rd_en  input  1  pop request; ignored when empty
- rd_data  output  8  head-of-FIFO byte; valid while empty=0
- empty  output  1  FIFO empty
- full  output  1  FIFO full
- count  output  $clog2(FIFO_DEPTH+1)  current occupancy
- frame_err  output  1  sticky: stop bit sampled low
- overrun  output  1  sticky: byte arrived while FIFO full
- clr_err  input  1  clears both sticky flags

Behaviour:
- Clocking and reset: one clock, `clk`. `reset` is asynchronous and active-high.
- Reset values: rd_data=0, empty=1, full=0, count=0, frame_err=0, overrun=0. Synchroniser flops reset to 1, FSM to IDLE, bit counter to 0.
- Input synchronisation: `rx` passes through a 2-flop synchroniser (rx_s). A third flop (rx_d) is used for falling-edge detection.
- FSM states and transitions:
  - IDLE: on rx_d=1 and rx_s=0, go to START with the cycle counter cleared. Detection is edge-based, so a held-low (break) line does not retrigger.
  - START: count to CPB/2-1, then sample. If rx_s=1 it is a glitch: go to IDLE, no error. If rx_s=0, clear the counter and go to DATA.
  - DATA: sample at counter=CPB-1 and shift into the shift register LSB-first. After the 8th sample go to STOP (or PARITY when the optional feature is enabled).
  - STOP: sample at CPB-1.
    - rx_s=1: push the byte into the FIFO, go to IDLE.
    - rx_s=0: set frame_err, discard the byte, go to IDLE.
- Latency: the push happens on the stop-sample clock edge. empty falls, and count/rd_data update, on that same edge, so they are visible the following cycle. Total latency from the start-bit falling edge at the pin is about 2 + CPB/2 + 9*CPB cycles.
- FIFO read port: show-ahead. rd_data always reflects the head entry. rd_en with empty=0 pops on the clock edge; rd_en with empty=1 has no effect.
- FIFO pointers: write and read pointers wrap modulo FIFO_DEPTH. count is maintained explicitly; full = (count == FIFO_DEPTH).
- Push while full:
  - Without a simultaneous pop: the byte is dropped, overrun is set, contents are unchanged.
  - With a simultaneous pop (rd_en=1): the push is accepted, count is unchanged, overrun is not set.
- Simultaneous push and pop when not full or empty: both occur, count is unchanged.
- Push into empty FIFO with rd_en=1 in the same cycle: the pop is ignored (the FIFO was empty), and the byte becomes visible the next cycle.
- clr_err: clears frame_err and overrun on the next edge. If a new error occurs in the same cycle, set wins.
- Mid-frame reset: the FSM returns to IDLE, the FIFO is emptied, and the partial byte is lost. After reset release, a line still low does not start a frame until a new high-to-low edge.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- With the macro defined:
  - A PARITY state is inserted between DATA and STOP. The bit is sampled at CPB-1.
  - Even parity is checked over data plus parity bit.
  - On mismatch the byte is dropped and a sticky `parity_err` output port (1 bit) is set. It resets to 0 and is cleared by clr_err.
- Without the macro: 8N1 framing, and no parity state or port exists.

Decomposition:
- Shared package uart_pkg holds:
  - the rx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - a CPB calculation function;
  - the constant DATA_BITS=8.
- Sub-module sync_fifo: parameterised width and depth, show-ahead read, with count/full/empty outputs. Overrun detection stays in uart_rx_fifo.

Test Plan:
All scenarios use CLOCK_FREQ=1000000 and BIT_RATE=100000, giving CPB=10.
- Single byte: drive frame 0xA5 (8N1) -> after the stop sample, empty=0, count=1, rd_data=0xA5. Pulse rd_en -> empty=1, count=0.
- Glitch rejection: rx low for 3 cycles then high -> FSM returns to IDLE, count=0, frame_err=0.
- Framing error: send 0x3C with stop bit low -> frame_err=1, count=0. clr_err -> frame_err=0 the next cycle.
- Overrun: send 17 bytes 0x00..0x10 with no reads -> full=1 after the 16th byte, overrun=1 after the 17th. Reads return 0x00..0x0F in order.
- Full plus simultaneous pop: fill 16 bytes, assert rd_en on the 17th push cycle -> overrun=0, count=16, last entry=0x10.
- Reset mid-frame: assert reset during DATA bit 4 -> all outputs return to reset values. A following clean 0x5A frame is received correctly.
